prbs_burst_ctrl: RTL and testbench

Burst sequencer for the PRBS7 pattern source. It accepts a command (seed plus bit count) over a valid/ready handshake, loads and steps an embedded PRBS7 LFSR core, and streams exactly the requested number of bits downstream with backpressure. It sits between a host or test controller and the serial/PHY test path, and replaces free-running PRBS output with controlled, repeatable bursts.

---
 rtl/prbs_pkg.sv | 31 +++
 rtl/prbs7_core.sv | 40 ++++
 rtl/prbs_burst_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_prbs_burst_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_pkg
//  Description : Shared types and constants for the PRBS7 burst sequencer:
//                controller state encoding, PRBS7 polynomial constants and
//                the LFSR next-state helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    // PRBS7 polynomial x^7 + x^6 + 1
    localparam int PRBS7_W      = 7;
    localparam int PRBS7_TAP_A  = 6;
    localparam int PRBS7_TAP_B  = 5;
    localparam int PRBS7_PERIOD = 127;

    // Burst controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One LFSR step: shift left, feedback from the two taps into bit 0
    function automatic logic [PRBS7_W-1:0] prbs7_next(input logic [PRBS7_W-1:0] s);
        return {s[PRBS7_W-2:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs7_core.sv
`default_nettype none
// ============================================================================
//  Module      : prbs7_core
//  Description : PRBS7 LFSR (x^7 + x^6 + 1). Loads a seed on i_load, steps
//                once per cycle on i_step and otherwise holds. The output bit
//                is the MSB of the state.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs7_core
    import prbs_pkg::*;
#(
    parameter logic [PRBS7_W-1:0] SEED_DEFAULT = 7'h7F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [PRBS7_W-1:0] i_seed,
    input  logic               i_step,
    output logic [PRBS7_W-1:0] o_state,
    output logic               o_bit
);

    logic [PRBS7_W-1:0] r_state;

    // LFSR register: load has priority over step, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED_DEFAULT;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= prbs7_next(r_state);
        end
    end

    assign o_state = r_state;
    assign o_bit   = r_state[PRBS7_W-1];

endmodule
`default_nettype wire

// File: rtl/prbs_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_burst_ctrl
//  Description : Burst sequencer around a PRBS7 LFSR. Accepts a command
//                (seed + bit count) over valid/ready, loads the LFSR and
//                streams exactly the requested number of bits downstream
//                with backpressure. Supports abort of an active burst.
//                Optional build macro PRBS_ERR_INJECT_EN adds ports inj_en /
//                inj_idx to invert one selected bit of the burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs_burst_ctrl
    import prbs_pkg::*;
#(
    parameter int                 LEN_W        = 16,
    parameter logic [PRBS7_W-1:0] SEED_DEFAULT = 7'h7F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [PRBS7_W-1:0] cmd_seed,
    input  logic               abort,
    output logic               bit_valid,
    input  logic               bit_ready,
    output logic               bit_data,
    output logic               bit_last,
    output logic               busy,
    output logic               done,
    output logic               aborted
`ifdef PRBS_ERR_INJECT_EN
    ,
    input  logic               inj_en,
    input  logic [LEN_W-1:0]   inj_idx
`endif
);

    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [PRBS7_W-1:0] r_seed_q;
    logic               r_cmd_ready;
    logic               r_bit_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;

    logic               w_cmd_take;
    logic               w_xfer;
    logic               w_lfsr_load;
    logic               w_lfsr_bit;
    logic [PRBS7_W-1:0] w_lfsr_state;
    logic               w_inj_hit;
    logic               w_unused_lfsr_state;

    // bit_valid is only ever high in RUN, so it doubles as the RUN decode
    assign w_cmd_take  = r_cmd_ready & cmd_valid;
    assign w_xfer      = r_bit_valid & bit_ready;
    assign w_lfsr_load = (r_state == LOAD);

    prbs7_core #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_prbs7_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_lfsr_load),
        .i_seed  (r_seed_q),
        .i_step  (w_xfer),
        .o_state (w_lfsr_state),
        .o_bit   (w_lfsr_bit)
    );

    // Only the output bit of the LFSR drives the stream; the full state is
    // available from the core for observation but not needed here.
    assign w_unused_lfsr_state = ^w_lfsr_state;

`ifdef PRBS_ERR_INJECT_EN
    logic             r_inj_en;
    logic [LEN_W-1:0] r_inj_idx;
    logic [LEN_W-1:0] r_bit_idx;

    // Capture the injection request at accept and track the 0-based index of
    // the bit currently presented on bit_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inj_en  <= 1'b0;
            r_inj_idx <= '0;
            r_bit_idx <= '0;
        end else begin
            if (w_cmd_take) begin
                r_inj_en  <= inj_en;
                r_inj_idx <= inj_idx;
            end
            if (w_lfsr_load) begin
                r_bit_idx <= '0;
            end else if (w_xfer) begin
                r_bit_idx <= r_bit_idx + c_len_one;
            end
        end
    end

    // Inversion is applied on the output only; the LFSR keeps its sequence
    assign w_inj_hit = r_inj_en & (r_bit_idx == r_inj_idx);
`else
    assign w_inj_hit = 1'b0;
`endif

    // Controller FSM with registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_seed_q    <= SEED_DEFAULT;
            r_cmd_ready <= 1'b1;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_remaining <= cmd_len;
                        // An all-zero seed would lock the LFSR
                        r_seed_q    <= (cmd_seed == '0) ? SEED_DEFAULT : cmd_seed;
                        r_cmd_ready <= 1'b0;
                        if (cmd_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (abort) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state     <= RUN;
                        r_bit_valid <= 1'b1;
                    end
                end

                RUN: begin
                    // A transfer coinciding with abort still completes
                    if (w_xfer) begin
                        r_remaining <= r_remaining - c_len_one;
                    end
                    if (abort || (w_xfer && (r_remaining == c_len_one))) begin
                        r_state     <= DONE;
                        r_bit_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_aborted   <= abort;
                    end
                end

                DONE: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_done      <= 1'b0;
                    r_aborted   <= 1'b0;
                end

                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_bit_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_aborted   <= 1'b0;
                end
            endcase
        end
    end

    // Data and last are gated by the registered valid, so they read zero
    // outside RUN and hold while stalled because the LFSR and count freeze
    assign cmd_ready = r_cmd_ready;
    assign bit_valid = r_bit_valid;
    assign bit_data  = r_bit_valid & (w_lfsr_bit ^ w_inj_hit);
    assign bit_last  = r_bit_valid & (r_remaining == c_len_one);
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_prbs_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs_burst_ctrl
//  Description : Self-checking bench for prbs_burst_ctrl. The reference bit
//                stream comes from the PRBS7 output recurrence
//                b[k+7] = b[k] ^ b[k+1] seeded with the seed bits MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_burst_ctrl;
    import prbs_pkg::*;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [6:0]       cmd_seed = '0;
    logic             abort = 1'b0;
    logic             bit_valid;
    logic             bit_ready = 1'b0;
    logic             bit_data;
    logic             bit_last;
    logic             busy;
    logic             done;
    logic             aborted;
`ifdef PRBS_ERR_INJECT_EN
    logic             inj_en = 1'b0;
    logic [LEN_W-1:0] inj_idx = '0;
`endif

    prbs_burst_ctrl #(
        .LEN_W        (LEN_W),
        .SEED_DEFAULT (7'h7F)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_seed  (cmd_seed),
        .abort     (abort),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_data  (bit_data),
        .bit_last  (bit_last),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
`ifdef PRBS_ERR_INJECT_EN
        ,
        .inj_en    (inj_en),
        .inj_idx   (inj_idx)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model
    logic exp_bits [0:511];
    int   exp_len = 0;
    logic inj_on  = 1'b0;
    int   inj_i   = 0;

    function automatic void gen_ref(input logic [6:0] seed, input int n);
        logic [6:0] s;
        s = (seed == 7'h00) ? 7'h7F : seed;
        for (int i = 0; i < 7; i++) exp_bits[i] = s[6-i];
        for (int i = 7; i < n && i < 512; i++) exp_bits[i] = exp_bits[i-7] ^ exp_bits[i-6];
    endfunction

    // Compare process: checks every presented bit against the model
    logic mon_en = 1'b0;
    int   xfer_cnt = 0;
    logic stall_prev = 1'b0;
    logic prev_data = 1'b0;
    logic prev_last = 1'b0;
    logic cap [0:511];

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            xfer_cnt   <= 0;
            stall_prev <= 1'b0;
        end else begin
            if (bit_valid) begin
                chk("bit_in_range", 32'(xfer_cnt < exp_len), 32'd1);
                if (xfer_cnt < exp_len && xfer_cnt < 512) begin
                    chk("bit_data", 32'(bit_data),
                        32'(exp_bits[xfer_cnt] ^ (inj_on && xfer_cnt == inj_i)));
                    chk("bit_last", 32'(bit_last), 32'(xfer_cnt == exp_len - 1));
                end
                if (stall_prev) begin
                    chk("stall_data", 32'(bit_data), 32'(prev_data));
                    chk("stall_last", 32'(bit_last), 32'(prev_last));
                end
            end
            if (bit_valid && bit_ready) begin
                if (xfer_cnt < 512) cap[xfer_cnt] <= bit_data;
                xfer_cnt <= xfer_cnt + 1;
            end
            stall_prev <= bit_valid && !bit_ready;
            prev_data  <= bit_data;
            prev_last  <= bit_last;
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        chk({tag, "_bit_data"},  32'(bit_data),  32'd0);
        chk({tag, "_bit_last"},  32'(bit_last),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_aborted"},   32'(aborted),   32'd0);
    endtask

    // One command from accept through the cycle after done
    task automatic run_burst(input int len, input logic [6:0] seed, input bit rnd,
                             input int abort_after, input bit poke);
        int  k;
        int  w;
        bit  got_done;
        bit  saw_valid;
        bit  saw_busy;
        int  exp_xfers;
        mon_en = 1'b0;
        @(negedge clk);
        gen_ref(seed, len);
        exp_len = len;
        @(posedge clk); #1;
        mon_en = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        cmd_seed  = seed;
        bit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("accept_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("accept_busy", 32'(busy), 32'(len != 0));
        k = 0;
        got_done  = done;
        saw_valid = bit_valid;
        saw_busy  = (len == 0) ? busy : 1'b0;
        while (!got_done && k < 4 * len + 20) begin
            bit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            abort = (abort_after >= 0) && (xfer_cnt == abort_after - 1) && bit_valid && bit_ready;
            if (poke) begin
                cmd_valid = 1'b1;
                cmd_len   = LEN_W'(5);
                chk("poke_cmd_ready_low", 32'(cmd_ready), 32'd0);
            end
            @(posedge clk); #1;
            abort = 1'b0;
            k++;
            if (bit_valid) saw_valid = 1'b1;
            if (busy) saw_busy = 1'b1;
            got_done = done;
        end
        cmd_valid = 1'b0;
        chk("done_seen", 32'(got_done), 32'd1);
        if (!rnd && abort_after < 0)
            chk("done_latency", 32'(k), 32'((len == 0) ? 0 : len + 1));
        exp_xfers = (abort_after >= 0) ? abort_after : len;
        chk("xfer_count", 32'(xfer_cnt), 32'(exp_xfers));
        chk("aborted_at_done", 32'(aborted), 32'(abort_after >= 0));
        if (len == 0) begin
            chk("zero_len_no_valid", 32'(saw_valid), 32'd0);
            chk("zero_len_no_busy", 32'(saw_busy), 32'd0);
        end
        @(posedge clk); #1;
        chk("after_done_pulse", 32'(done), 32'd0);
        chk("after_done_aborted", 32'(aborted), 32'd0);
        chk("after_done_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_not_busy", 32'(busy), 32'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        logic [14:0] pin;
        logic [7:0]  got8;
        int          pbad;

        // Model pins: first 15 bits from seed 7F, and seed 0 maps to 7F
        gen_ref(7'h00, 16);
        pin = 15'b111111100000010;
        for (int i = 0; i < 15; i++) chk("model_pin", 32'(exp_bits[i]), 32'(pin[14-i]));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_values("after_reset");

        // Basic burst, seed 7F, len 8
        run_burst(8, 7'h7F, 1'b0, -1, 1'b0);
        for (int i = 0; i < 8; i++) got8[7-i] = cap[i];
        chk("burst8_bits", 32'(got8), 32'h000000FE);

        // Seed 0 substitution over a full period, then a double period
        run_burst(127, 7'h00, 1'b0, -1, 1'b0);
        run_burst(254, 7'h7F, 1'b0, -1, 1'b0);
        pbad = 0;
        for (int i = 0; i < PRBS7_PERIOD; i++)
            if (cap[i + PRBS7_PERIOD] !== cap[i]) pbad++;
        chk("period_repeat", 32'(pbad), 32'd0);

        // Random backpressure
        run_burst(20, 7'h35, 1'b1, -1, 1'b0);
        run_burst(33, 7'h01, 1'b1, -1, 1'b0);

        // Zero length
        run_burst(0, 7'h12, 1'b0, -1, 1'b0);

        // Abort on the 10th transfer, with a command offered during the burst
        run_burst(100, 7'h5A, 1'b0, 10, 1'b1);

        // Single-bit burst
        run_burst(1, 7'h40, 1'b0, -1, 1'b0);

`ifdef PRBS_ERR_INJECT_EN
        inj_en  = 1'b1;
        inj_idx = LEN_W'(3);
        inj_on  = 1'b1;
        inj_i   = 3;
        run_burst(10, 7'h7F, 1'b0, -1, 1'b0);
        for (int i = 0; i < 8; i++) got8[7-i] = cap[i];
        chk("inject_bits", 32'(got8), 32'h000000EE);
        inj_en = 1'b0;
        inj_on = 1'b0;
`endif

        // Reset asserted mid-burst
        mon_en = 1'b0;
        @(negedge clk);
        gen_ref(7'h2B, 50);
        exp_len = 50;
        @(posedge clk); #1;
        mon_en    = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(50);
        cmd_seed  = 7'h2B;
        bit_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(bit_valid), 32'd1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        repeat (2) @(posedge clk);
        #1;
        chk("reset_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", 32'(cmd_ready), 32'd1);
        run_burst(8, 7'h7F, 1'b0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
